// File: rtl/chase_steer.sv
// chase_steer: once per camera frame, samples the colour tracker's centroid
// column and radius, decides whether a target is present, and derives
// left/right motor duties that steer the chasebot toward the target. After
// LOST_FRAMES consecutive empty frames it spins to search. It also drives the
// two motor PWM outputs and their direction bits.
//
// Ports:
//   clk          system clock (pixel clock)
//   rst_in       synchronous reset, active-low
//   vsync        frame sync, same clock domain; the falling edge starts a sample
//   x_center     tracker centroid column
//   radius       tracker target radius
//   pwm_left     left motor PWM (registered)
//   pwm_right    right motor PWM (registered)
//   dir_left     left direction, 1 = forward (constant in this revision)
//   dir_right    right direction, 1 = forward (constant in this revision)
//   target_valid last sampled frame held a valid target
//   lost         search mode active
//   duty_left    left duty currently applied to the PWM
//   duty_right   right duty currently applied to the PWM
//
// Handshake: there is no valid/ready pair. A frame is requested by a vsync
// falling edge, and the result is always accepted: pending duties are written
// SETTLE+2 clocks after the fall and reach the PWM at the next PWM period start.
module chase_steer #(
  parameter int H_CENTER    = 512,
  parameter int H_ACTIVE    = 1024,
  parameter int MIN_RADIUS  = 4,
  parameter int STOP_RADIUS = 80,
  parameter int DEAD        = 16,
  parameter int STEER_SHIFT = 2,
  parameter int BASE_DUTY   = 160,
  parameter int SEARCH_DUTY = 96,
  parameter int LOST_FRAMES = 8,
  parameter int SETTLE      = 64,
  parameter int PWM_DIV     = 256
) (
  input  logic        clk,
  input  logic        rst_in,
  input  logic        vsync,
  input  logic [31:0] x_center,
  input  logic [23:0] radius,
  output logic        pwm_left,
  output logic        pwm_right,
  output logic        dir_left,
  output logic        dir_right,
  output logic        target_valid,
  output logic        lost,
  output logic [7:0]  duty_left,
  output logic [7:0]  duty_right
);

  localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam int PW = (PWM_DIV > 1) ? $clog2(PWM_DIV) : 1;
  localparam int LW = $clog2(LOST_FRAMES + 1);

  typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_EVAL, S_APPLY} state_t;

  state_t          state_q, state_d;
  logic            vsync_q, vsync_d;
  logic [SW-1:0]   settle_q, settle_d;
  logic [10:0]     x_q, x_d;
  logic [23:0]     r_q, r_d;
  logic            valid_q, valid_d;
  logic            tv_q, tv_d;
  logic            lost_q, lost_d;
  logic [LW-1:0]   lcnt_q, lcnt_d;
  logic [7:0]      pend_l_q, pend_l_d, pend_r_q, pend_r_d;
  logic [7:0]      act_l_q, act_l_d, act_r_q, act_r_d;
  logic [PW-1:0]   pre_q, pre_d;
  logic [7:0]      pwm_cnt_q, pwm_cnt_d;
  logic            pwm_l_q, pwm_l_d, pwm_r_q, pwm_r_d;

  logic              fall;
  logic signed [11:0] err;
  logic [11:0]       err_abs;
  logic signed [11:0] steer;
  logic signed [10:0] base;
  logic signed [10:0] sum_l, sum_r;
  logic [LW-1:0]     lcnt_inc;
  logic              pre_wrap;

  function automatic logic [7:0] sat8(input logic signed [10:0] s);
    if (s < 11'sd0)        return 8'd0;
    else if (s > 11'sd255) return 8'd255;
    else                   return s[7:0];
  endfunction

  assign fall = vsync_q & ~vsync;

  // Steering math on the latched sample. x_q < 1024 for any valid frame, so a
  // 12-bit signed error cannot overflow.
  always_comb begin
    err     = $signed({1'b0, x_q}) - $signed(12'(H_CENTER));
    err_abs = err[11] ? 12'(-err) : 12'(err);
    steer   = (err_abs <= 12'(DEAD)) ? 12'sd0 : (err >>> STEER_SHIFT);
    base    = (r_q >= 24'(STOP_RADIUS)) ? 11'sd0 : $signed(11'(BASE_DUTY));
    sum_l   = base + $signed(steer[10:0]);
    sum_r   = base - $signed(steer[10:0]);
    lcnt_inc = (lcnt_q == LW'(LOST_FRAMES)) ? lcnt_q : lcnt_q + 1'b1;
  end

  always_comb begin
    state_d  = state_q;
    vsync_d  = vsync;
    settle_d = settle_q;
    x_d      = x_q;
    r_d      = r_q;
    valid_d  = valid_q;
    tv_d     = tv_q;
    lost_d   = lost_q;
    lcnt_d   = lcnt_q;
    pend_l_d = pend_l_q;
    pend_r_d = pend_r_q;

    case (state_q)
      S_IDLE: begin
        if (fall) begin
          state_d  = S_SETTLE;
          settle_d = '0;
        end
      end
      S_SETTLE: begin
        // A new frame edge during settling restarts the full wait.
        if (fall)                             settle_d = '0;
        else if (settle_q == SW'(SETTLE - 1)) state_d  = S_EVAL;
        else                                  settle_d = settle_q + 1'b1;
      end
      S_EVAL: begin
        x_d     = x_center[10:0];
        r_d     = radius;
        valid_d = (radius >= 24'(MIN_RADIUS)) && (x_center < 32'(H_ACTIVE));
        state_d = S_APPLY;
      end
      S_APPLY: begin
        if (valid_q) begin
          pend_l_d = sat8(sum_l);
          pend_r_d = sat8(sum_r);
          lcnt_d   = '0;
          lost_d   = 1'b0;
          tv_d     = 1'b1;
        end else begin
          tv_d   = 1'b0;
          lcnt_d = lcnt_inc;
          // Below the threshold the previous duties are simply held.
          if (lcnt_inc == LW'(LOST_FRAMES)) begin
            lost_d   = 1'b1;
            pend_l_d = 8'(SEARCH_DUTY);
            pend_r_d = 8'd0;
          end
        end
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // PWM: active duties only change at the start of a PWM period, so a period
  // in progress always completes with the width it started with.
  always_comb begin
    pre_wrap  = (pre_q == PW'(PWM_DIV - 1));
    pre_d     = pre_wrap ? '0 : pre_q + 1'b1;
    pwm_cnt_d = pre_wrap ? pwm_cnt_q + 8'd1 : pwm_cnt_q;
    act_l_d   = act_l_q;
    act_r_d   = act_r_q;
    if (pre_wrap && (pwm_cnt_q == 8'hFF)) begin
      act_l_d = pend_l_q;
      act_r_d = pend_r_q;
    end
    pwm_l_d = (pwm_cnt_q < act_l_q);
    pwm_r_d = (pwm_cnt_q < act_r_q);
  end

  always_ff @(posedge clk) begin
    if (!rst_in) begin
      state_q   <= S_IDLE;
      vsync_q   <= 1'b1;
      settle_q  <= '0;
      x_q       <= '0;
      r_q       <= '0;
      valid_q   <= 1'b0;
      tv_q      <= 1'b0;
      lost_q    <= 1'b0;
      lcnt_q    <= '0;
      pend_l_q  <= '0;
      pend_r_q  <= '0;
      act_l_q   <= '0;
      act_r_q   <= '0;
      pre_q     <= '0;
      pwm_cnt_q <= '0;
      pwm_l_q   <= 1'b0;
      pwm_r_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      vsync_q   <= vsync_d;
      settle_q  <= settle_d;
      x_q       <= x_d;
      r_q       <= r_d;
      valid_q   <= valid_d;
      tv_q      <= tv_d;
      lost_q    <= lost_d;
      lcnt_q    <= lcnt_d;
      pend_l_q  <= pend_l_d;
      pend_r_q  <= pend_r_d;
      act_l_q   <= act_l_d;
      act_r_q   <= act_r_d;
      pre_q     <= pre_d;
      pwm_cnt_q <= pwm_cnt_d;
      pwm_l_q   <= pwm_l_d;
      pwm_r_q   <= pwm_r_d;
    end
  end

  assign pwm_left     = pwm_l_q;
  assign pwm_right    = pwm_r_q;
  assign dir_left     = 1'b1;
  assign dir_right    = 1'b1;
  assign target_valid = tv_q;
  assign lost         = lost_q;
  assign duty_left    = act_l_q;
  assign duty_right   = act_r_q;

endmodule

// File: tb/tb_chase_steer.sv
// Testbench for chase_steer. PWM_DIV is reduced to 2 so one PWM period is
// 512 clocks; all other parameters keep their default values.
module tb_chase_steer;

  localparam int PDIV   = 2;
  localparam int PERIOD = 256 * PDIV;

  logic        clk = 1'b0;
  logic        rst_in;
  logic        vsync;
  logic [31:0] x_center;
  logic [23:0] radius;
  logic        pwm_left, pwm_right, dir_left, dir_right;
  logic        target_valid, lost;
  logic [7:0]  duty_left, duty_right;

  int total = 0;
  int bad   = 0;

  // Expected {target_valid, lost, duty_left, duty_right} per frame.
  logic [17:0] exp_q[$];

  // Last PERIOD samples of each PWM output, taken at every falling edge.
  logic ring_l [PERIOD];
  logic ring_r [PERIOD];
  int   ridx = 0;

  chase_steer #(.PWM_DIV(PDIV)) dut (
    .clk(clk), .rst_in(rst_in), .vsync(vsync), .x_center(x_center),
    .radius(radius), .pwm_left(pwm_left), .pwm_right(pwm_right),
    .dir_left(dir_left), .dir_right(dir_right), .target_valid(target_valid),
    .lost(lost), .duty_left(duty_left), .duty_right(duty_right)
  );

  // clock / reset block
  always #5 clk = ~clk;

  initial begin
    for (int i = 0; i < PERIOD; i++) begin
      ring_l[i] = 1'b0;
      ring_r[i] = 1'b0;
    end
  end

  always @(negedge clk) begin
    ring_l[ridx] = pwm_left;
    ring_r[ridx] = pwm_right;
    ridx = (ridx + 1) % PERIOD;
  end

  function automatic int ring_sum(input bit right);
    int s = 0;
    for (int i = 0; i < PERIOD; i++) s += right ? int'(ring_r[i]) : int'(ring_l[i]);
    return s;
  endfunction

  // Each tick lands just after a falling edge, away from the active edge.
  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic start_frame(input int x, input int r, input int el, input int er,
                             input bit etv, input bit elost);
    x_center = 32'(x);
    radius   = 24'(r);
    exp_q.push_back({etv, elost, 8'(el), 8'(er)});
    vsync = 1'b0;
    tick(1);
    vsync = 1'b1;
  endtask

  task automatic finish_frame(input string tag, input int wait_clks);
    logic [17:0] e;
    tick(wait_clks);
    if (exp_q.size() == 0) begin
      total++;
      bad++;
      $error("FAIL %s observed=empty_queue expected=entry", tag);
    end else begin
      e = exp_q.pop_front();
      chk({tag, "_tv"},   32'(target_valid), 32'(e[17]));
      chk({tag, "_lost"}, 32'(lost),         32'(e[16]));
      chk({tag, "_dl"},   32'(duty_left),    32'(e[15:8]));
      chk({tag, "_dr"},   32'(duty_right),   32'(e[7:0]));
    end
  endtask

  task automatic frame(input string tag, input int x, input int r, input int el,
                       input int er, input bit etv, input bit elost);
    start_frame(x, r, el, er, etv, elost);
    finish_frame(tag, 620);
  endtask

  initial begin
    int  waited;
    bit  seen;

    // Reset with random inputs.
    rst_in   = 1'b0;
    vsync    = 1'b1;
    x_center = '0;
    radius   = '0;
    for (int i = 0; i < 5; i++) begin
      vsync    = 1'($urandom_range(0, 1));
      x_center = 32'($urandom_range(0, 2047));
      radius   = 24'($urandom_range(0, 200));
      tick(1);
      chk("rst_pwm_l", 32'(pwm_left),     32'd0);
      chk("rst_pwm_r", 32'(pwm_right),    32'd0);
      chk("rst_dir",   32'({dir_left, dir_right}), 32'd3);
      chk("rst_tv",    32'(target_valid), 32'd0);
      chk("rst_lost",  32'(lost),         32'd0);
      chk("rst_duty",  32'({duty_left, duty_right}), 32'd0);
    end
    vsync  = 1'b1;
    rst_in = 1'b1;
    tick(3);

    // Centred target, with result timing.
    start_frame(520, 20, 160, 160, 1'b1, 1'b0);
    tick(64);
    chk("centre_tv_early", 32'(target_valid), 32'd0);
    tick(2);
    chk("centre_tv_on_time", 32'(target_valid), 32'd1);
    finish_frame("centre", 600);
    tick(520);
    chk("centre_pwm_l_width", 32'(ring_sum(1'b0)), 32'(160 * PDIV));
    chk("centre_pwm_r_width", 32'(ring_sum(1'b1)), 32'(160 * PDIV));

    // Right turns, the second saturating the left wheel.
    frame("right", 612, 20, 185, 135, 1'b1, 1'b0);
    frame("right_sat", 1000, 20, 255, 38, 1'b1, 1'b0);
    tick(520);
    chk("sat_pwm_l_width", 32'(ring_sum(1'b0)), 32'(255 * PDIV));
    chk("sat_pwm_r_width", 32'(ring_sum(1'b1)), 32'(38 * PDIV));

    // Close target: base speed zero, left saturates low.
    frame("close", 300, 90, 0, 53, 1'b1, 1'b0);
    tick(520);
    chk("close_pwm_l_width", 32'(ring_sum(1'b0)), 32'd0);
    chk("close_pwm_r_width", 32'(ring_sum(1'b1)), 32'(53 * PDIV));

    // Loss and search.
    frame("pre_loss", 520, 20, 160, 160, 1'b1, 1'b0);
    for (int i = 0; i < 7; i++)
      frame("loss_hold", 520, 0, 160, 160, 1'b0, 1'b0);
    frame("loss_search", 520, 0, 96, 0, 1'b0, 1'b1);
    frame("loss_sat", 520, 2, 96, 0, 1'b0, 1'b1);
    frame("reacquire", 520, 20, 160, 160, 1'b1, 1'b0);

    // Column at the active width is invalid; duties held.
    frame("x_1024", 1024, 20, 160, 160, 1'b0, 1'b0);

    // New duty issued mid-period: the running period keeps its width.
    tick(520);
    start_frame(612, 20, 185, 135, 1'b1, 1'b0);
    seen   = 1'b0;
    waited = 0;
    while (!seen && waited < 1200) begin
      tick(1);
      waited++;
      if (duty_left !== 8'd160) seen = 1'b1;
    end
    if (!seen) begin
      total++;
      bad++;
      $error("FAIL glitch_update observed=no_change expected=change_within_1200");
    end else begin
      chk("glitch_old_width", 32'(ring_sum(1'b0)), 32'(160 * PDIV));
      chk("glitch_new_duty",  32'(duty_left), 32'd185);
      tick(PERIOD);
      chk("glitch_new_width", 32'(ring_sum(1'b0)), 32'(185 * PDIV));
    end
    finish_frame("glitch", 10);

    // A second fall during settling restarts the wait.
    frame("retrig_pre", 1024, 20, 185, 135, 1'b0, 1'b0);
    start_frame(1000, 20, 255, 38, 1'b1, 1'b0);
    tick(29);
    vsync = 1'b0;
    tick(1);
    vsync = 1'b1;
    tick(36);
    chk("retrig_first_deadline", 32'(target_valid), 32'd0);
    tick(29);
    chk("retrig_before_full", 32'(target_valid), 32'd0);
    tick(1);
    chk("retrig_after_full", 32'(target_valid), 32'd1);
    finish_frame("retrig", 620);

    chk("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/chase_steer.md
Name: chase_steer

Overview:
Downstream consumer of the colour tracker's per-frame centroid and radius outputs. Once per camera frame it samples x_center and radius, decides whether the target is present, and computes left/right motor duty cycles that steer the chasebot toward the target. It approaches the target until it is close, and searches by spinning once the target has been lost for several frames. It also generates the two motor PWM waveforms and direction bits.

Parameters:
H_CENTER, 512, image column treated as straight ahead
H_ACTIVE, 1024, x_center at or above this value is invalid
MIN_RADIUS, 4, radius below this means no target
STOP_RADIUS, 80, radius at or above this means close enough, base speed forced to 0
DEAD, 16, steering deadband, compared against |err|
STEER_SHIFT, 2, steer = err >>> STEER_SHIFT (arithmetic shift)
BASE_DUTY, 160, forward duty (0..255)
SEARCH_DUTY, 96, left-wheel duty while searching
LOST_FRAMES, 8, consecutive invalid frames before search starts
SETTLE, 64, clocks to wait after vsync fall before sampling
PWM_DIV, 256, clocks per PWM counter step

Ports:
clk  in  1  system clock (65 MHz pixel clock)
rst_in  in  1  synchronous reset, active-low
vsync  in  1  frame sync, same clock domain
x_center  in  32  tracker centroid column
radius  in  24  tracker target radius
pwm_left  out  1  left motor PWM
pwm_right  out  1  right motor PWM
dir_left  out  1  1 = forward; always 1 in this revision
dir_right  out  1  1 = forward; always 1 in this revision
target_valid  out  1  last sampled frame held a valid target
lost  out  1  search mode active
duty_left  out  8  current applied left duty
duty_right  out  8  current applied right duty

Behaviour:
- Reset (rst_in==0 at a clk edge): FSM=IDLE; all duties=0; pwm_left/pwm_right=0; dir_left/dir_right=1; target_valid=0; lost=0; lost counter=0; prescaler=0; PWM counter=0. Reset mid-frame or mid-SETTLE abandons the sample; nothing is latched.
- vsync edge detect: register vsync_q; fall = vsync_q & ~vsync. vsync_q resets to 1.
- FSM states:
  - IDLE: wait for fall, then go to SETTLE with the settle counter cleared.
  - SETTLE: count to SETTLE-1, then go to EVAL. A fall seen during SETTLE restarts the count.
  - EVAL, 1 cycle: latch x_center[10:0] and radius. valid = (radius>=MIN_RADIUS) && (x_center<H_ACTIVE). Compute next duties. Go to APPLY.
  - APPLY, 1 cycle: write the pending duties, then go to IDLE.
- Duty computation when valid:
  - err = signed 12-bit (x - H_CENTER).
  - steer = 0 if |err|<=DEAD, else err>>>STEER_SHIFT.
  - base = 0 if radius>=STOP_RADIUS, else BASE_DUTY.
  - left = base+steer, right = base-steer. Compute in signed 11-bit and saturate to 0..255.
  - Clear the lost counter and lost; set target_valid=1.
- Duty computation when invalid:
  - target_valid=0; lost counter increments, saturating at LOST_FRAMES.
  - If the counter (after increment) < LOST_FRAMES: hold the previous duties.
  - If the counter == LOST_FRAMES: lost=1, left=SEARCH_DUTY, right=0.
- PWM:
  - The prescaler counts 0..PWM_DIV-1. At wrap, the 8-bit PWM counter increments, wrapping 255->0.
  - pwm_x = (pwm_cnt < active_duty_x), registered.
  - active_duty registers take the pending duties only when the PWM counter wraps 255->0 at a prescaler wrap. This makes updates glitch-free. duty_left/duty_right report the active values.
  - Duty 0 gives constant low; duty 255 gives 255/256 high.
- Latency: first active_duty change occurs no earlier than SETTLE+2 clocks after the vsync fall, plus up to one full PWM period.

Test Plan:
- Reset: hold rst_in=0 for 5 clocks with random inputs -> all outputs at reset values, dir=1, pwm low for the whole time.
- Centred target: x=520, radius=20, pulse vsync -> err=8, inside deadband -> duties 160/160, target_valid=1 after SETTLE+2 clocks, pwm high 160 of every 256 PWM steps.
- Right turn with saturation: x=612, r=20 -> 185/135; then x=1000, r=20 -> err=488, steer=122 -> 255/38.
- Close target: x=300, r=90 -> err=-212, steer=-53, base=0 -> left saturates to 0, right=53.
- Loss and search: valid frame (160/160), then 7 frames with radius=0 -> duties held, lost=0; 8th frame -> lost=1, duties 96/0; next valid frame clears lost.
- Glitch/boundary: apply a new duty mid-PWM-period -> pwm width of the current period unchanged and the new duty takes effect at the next 255->0 wrap; x_center=1024 -> treated as invalid; a second vsync fall during SETTLE restarts the wait (sample only after a full SETTLE).
